// File: rtl/io_seg7_out_port.sv
// Memory-mapped seven-segment output port: captures stores to OUT_ADDR and converts them
// to decimal with a sequential double-dabble engine. Optional build macro: SEG7_LZ_BLANK_EN.
module io_seg7_out_port #(
  parameter int         DATA_W   = 8,
  parameter int         DIGITS   = 2,
  parameter logic [7:0] OUT_ADDR = 8'h80
) (
  input  logic                  clock,
  input  logic                  resetn,
  input  logic                  io_wen,
  input  logic [7:0]            io_addr,
  input  logic [31:0]           io_wdata,
  output logic [DATA_W-1:0]     out_port,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  busy
);

  localparam int         BCD_W     = 40;
  localparam logic [5:0] LAST_SHIFT = 6'(DATA_W - 1);
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                   state;
  logic [DATA_W-1:0]        bin;
  logic [BCD_W-1:0]         bcd;
  logic [5:0]               count;
  logic                     pend_valid;
  logic [DATA_W-1:0]        pend_val;

  logic                     hit;
  logic [DATA_W-1:0]        wdata_cap;
  logic [DATA_W-1:0]        load_val;
  logic [BCD_W-1:0]         bcd_adj;
  logic [BCD_W+DATA_W-1:0]  sr_next;
  logic                     overflow;
  logic [7*DIGITS-1:0]      hex_next;

  assign hit       = io_wen && (io_addr == OUT_ADDR);
  assign wdata_cap = io_wdata[DATA_W-1:0];
  // A store landing in the DONE cycle outranks an older pending value.
  assign load_val  = (state == DONE && !hit) ? pend_val : wdata_cap;

  if (DATA_W < 32) begin : g_unused
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^io_wdata[31:DATA_W];
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = 7'h7F;
    endcase
  endfunction

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
    sr_next = {bcd_adj, bin} << 1;
  end

  always_comb begin
    overflow = |bcd[BCD_W-1:4*DIGITS];
    hex_next = '0;
    for (int d = 0; d < DIGITS; d++) begin
      hex_next[7*d +: 7] = overflow ? SEG_DASH : seg7(bcd[4*d +: 4]);
    end
`ifdef SEG7_LZ_BLANK_EN
    begin
      logic lz;
      lz = !overflow;
      for (int d = DIGITS - 1; d > 0; d--) begin
        if (lz && bcd[4*d +: 4] == 4'd0) hex_next[7*d +: 7] = 7'b1111111;
        else                             lz = 1'b0;
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state      <= IDLE;
      out_port   <= '0;
      busy       <= 1'b0;
      bin        <= '0;
      bcd        <= '0;
      count      <= '0;
      pend_valid <= 1'b0;
      pend_val   <= '0;
      hex        <= {DIGITS{SEG_ZERO}};
    end else begin
      if (hit) out_port <= wdata_cap;
      case (state)
        IDLE: begin
          if (hit) begin
            bin   <= load_val;
            bcd   <= '0;
            count <= '0;
            busy  <= 1'b1;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (hit) begin
            pend_valid <= 1'b1;
            pend_val   <= wdata_cap;
          end
          bcd   <= sr_next[BCD_W+DATA_W-1:DATA_W];
          bin   <= sr_next[DATA_W-1:0];
          count <= count + 6'd1;
          if (count == LAST_SHIFT) state <= DONE;
        end
        DONE: begin
          hex <= hex_next;
          if (hit || pend_valid) begin
            bin        <= load_val;
            bcd        <= '0;
            count      <= '0;
            pend_valid <= 1'b0;
            state      <= SHIFT;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_seg7_out_port.sv
// Directed self-checking bench for io_seg7_out_port (DATA_W=8, DIGITS=2, OUT_ADDR=8'h80).
module tb_io_seg7_out_port;

  localparam logic [6:0] S0 = 7'h40, S2 = 7'h24, S4 = 7'h19, S5 = 7'h12, S7 = 7'h78;
  localparam logic [6:0] DASH = 7'h3F;
`ifdef SEG7_LZ_BLANK_EN
  localparam logic [6:0] LZ = 7'h7F;
`else
  localparam logic [6:0] LZ = 7'h40;
`endif

  logic        clock = 1'b0;
  logic        resetn;
  logic        io_wen;
  logic [7:0]  io_addr;
  logic [31:0] io_wdata;
  logic [7:0]  out_port;
  logic [13:0] hex;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  io_seg7_out_port #(.DATA_W(8), .DIGITS(2), .OUT_ADDR(8'h80)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .io_wen   (io_wen),
    .io_addr  (io_addr),
    .io_wdata (io_wdata),
    .out_port (out_port),
    .hex      (hex),
    .busy     (busy)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $fatal(1, "FAIL watchdog: observed=timeout expected=finish");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; the hit lands on the following rising edge.
  task automatic store(input logic [7:0] a, input logic [31:0] d);
    io_wen   = 1'b1;
    io_addr  = a;
    io_wdata = d;
    @(negedge clock);
    io_wen   = 1'b0;
    io_addr  = '0;
    io_wdata = '0;
  endtask

  initial begin
    resetn = 1'b0; io_wen = 1'b0; io_addr = '0; io_wdata = '0;
    repeat (3) @(negedge clock);
    check("rst_hex",  32'(hex), 32'({S0, S0}));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_out",  32'(out_port), 32'd0);
    resetn = 1'b1;
    @(negedge clock);
    check("idle_hex",  32'(hex), 32'h2040);
    check("idle_busy", 32'(busy), 32'd0);

    // 42: busy for 9 cycles, display updates on the 9th edge after the hit.
    store(8'h80, 32'd42);
    check("s42_out",  32'(out_port), 32'd42);
    check("s42_busy", 32'(busy), 32'd1);
    repeat (8) @(negedge clock);
    check("s42_busy_late", 32'(busy), 32'd1);
    check("s42_hex_old",   32'(hex), 32'({S0, S0}));
    @(negedge clock);
    check("s42_busy_end", 32'(busy), 32'd0);
    check("s42_hex",      32'(hex), 32'({S4, S2}));

    // 150 does not fit two digits.
    store(8'h80, 32'd150);
    repeat (9) @(negedge clock);
    check("s150_hex",  32'(hex), 32'({DASH, DASH}));
    check("s150_busy", 32'(busy), 32'd0);
    check("s150_out",  32'(out_port), 32'd150);

    // Wrong address is ignored.
    store(8'h81, 32'd99);
    check("miss_out",  32'(out_port), 32'd150);
    check("miss_busy", 32'(busy), 32'd0);
    repeat (10) @(negedge clock);
    check("miss_hex",  32'(hex), 32'({DASH, DASH}));

    // 7, then 93 and 55 while busy: last write wins, 93 never shown.
    store(8'h80, 32'd7);
    @(negedge clock);
    @(negedge clock);
    store(8'h80, 32'd93);
    check("s93_out", 32'(out_port), 32'd93);
    store(8'h80, 32'd55);
    check("s55_out", 32'(out_port), 32'd55);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clock);
      check("chain_busy", 32'(busy), 32'd1);
      check("chain_hex",  32'(hex), (k <= 4) ? 32'({DASH, DASH}) : 32'({LZ, S7}));
    end
    @(negedge clock);
    check("s55_hex",  32'(hex), 32'({S5, S5}));
    check("s55_busy", 32'(busy), 32'd0);

    // Zero exercises leading-zero handling on the top digit.
    store(8'h80, 32'd0);
    repeat (9) @(negedge clock);
    check("s0_hex", 32'(hex), 32'({LZ, S0}));

    // Reset during the fourth shift cycle discards the conversion.
    store(8'h80, 32'd5);
    repeat (3) @(negedge clock);
    check("pre_rst_busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    #1;
    check("mid_rst_hex",  32'(hex), 32'h2040);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_out",  32'(out_port), 32'd0);
    #2;
    resetn = 1'b1;
    repeat (15) @(negedge clock);
    check("post_rst_hex",  32'(hex), 32'h2040);
    check("post_rst_busy", 32'(busy), 32'd0);

    store(8'h80, 32'd5);
    repeat (9) @(negedge clock);
    check("s5_hex", 32'(hex), 32'({LZ, S5}));
    check("s5_out", 32'(out_port), 32'd5);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
